// File: rtl/opll_bus_pkg.sv
// Shared definitions for the YM2413 host bus sequencer: FSM states, chip
// recovery times in phiM cycles, and the wait-counter load helpers.
package opll_bus_pkg;

   localparam int unsigned OPLL_ADDR_WAIT_PHIM = 12;
   localparam int unsigned OPLL_DATA_WAIT_PHIM = 84;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_ADDR_SETUP,
      ST_ADDR_STROBE,
      ST_ADDR_WAIT,
      ST_DATA_SETUP,
      ST_DATA_STROBE,
      ST_DATA_WAIT
   } opll_state_e;

   // A state lasting n cycles loads n-1; a wait of 0 still occupies one cycle.
   function automatic int unsigned wait_load(input int unsigned n);
      return (n == 0) ? 0 : n - 1;
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/opll_req_fifo.sv
// Synchronous request FIFO holding {addr, data} write requests; the head entry
// is presented combinationally and pointers wrap modulo DEPTH (power of two).
module opll_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [$clog2(DEPTH):0]   count_next_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_C);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign count_next_o = count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/opll_write_sequencer.sv
// Host-side write sequencer for the YM2413 core: buffers register writes and
// drives CS_n/WR_n/A0/D with strobe widths and recovery waits in phiM cycles.
module opll_write_sequencer
   import opll_bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STROBE_LEN = 4,
   parameter int unsigned ADDR_WAIT  = OPLL_ADDR_WAIT_PHIM,
   parameter int unsigned DATA_WAIT  = OPLL_DATA_WAIT_PHIM,
   parameter int unsigned INIT_WAIT  = 288,
   parameter int unsigned ADDR_CACHE = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [7:0]                    req_addr,
   input  logic [7:0]                    req_data,
   output logic                          o_CS_n,
   output logic                          o_WR_n,
   output logic                          o_A0,
   output logic [7:0]                    o_D,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CW   = $clog2(max4(INIT_WAIT, DATA_WAIT, ADDR_WAIT, STROBE_LEN) + 1);
   localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t LD_INIT   = cnt_t'(wait_load(INIT_WAIT));
   localparam cnt_t LD_STROBE = cnt_t'(wait_load(STROBE_LEN));
   localparam cnt_t LD_AWAIT  = cnt_t'(wait_load(ADDR_WAIT));
   localparam cnt_t LD_DWAIT  = cnt_t'(wait_load(DATA_WAIT));
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

   opll_state_e state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d, data_q, data_d;
   logic [7:0]  cache_q, cache_d;
   logic        cache_vld_q, cache_vld_d;
   logic        cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d;
   logic [7:0]  d_q, d_d;
   logic        ready_q, ready_d, busy_q, busy_d;

   logic            push, pop;
   logic [15:0]     head;
   logic [CNTW-1:0] cnt_fifo, cnt_fifo_next;
   logic            fifo_full, fifo_empty;

   assign push = req_valid & ready_q & ~fifo_full;

   opll_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .pop_i        (pop),
      .wdata_i      ({req_addr, req_data}),
      .rdata_o      (head),
      .count_o      (cnt_fifo),
      .count_next_o (cnt_fifo_next),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - cnt_t'(1);
      pop         = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      cache_d     = cache_q;
      cache_vld_d = cache_vld_q;
      unique case (state_q)
         ST_INIT: if (cnt_q == '0) state_d = ST_IDLE;
         ST_IDLE: if (!fifo_empty) begin
            pop    = 1'b1;
            addr_d = head[15:8];
            data_d = head[7:0];
            cnt_d  = '0;
            if ((ADDR_CACHE != 0) && cache_vld_q && (cache_q == head[15:8]))
               state_d = ST_DATA_SETUP;
            else
               state_d = ST_ADDR_SETUP;
         end
         ST_ADDR_SETUP: begin
            state_d = ST_ADDR_STROBE;
            cnt_d   = LD_STROBE;
         end
         ST_ADDR_STROBE: if (cnt_q == '0) begin
            state_d     = ST_ADDR_WAIT;
            cnt_d       = LD_AWAIT;
            cache_d     = addr_q;
            cache_vld_d = 1'b1;
         end
         ST_ADDR_WAIT: if (cnt_q == '0) begin
            state_d = ST_DATA_SETUP;
            cnt_d   = '0;
         end
         ST_DATA_SETUP: begin
            state_d = ST_DATA_STROBE;
            cnt_d   = LD_STROBE;
         end
         ST_DATA_STROBE: if (cnt_q == '0) begin
            state_d = ST_DATA_WAIT;
            cnt_d   = LD_DWAIT;
         end
         ST_DATA_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase

      // Bus pins are decoded from the state being entered so the registered
      // outputs line up with the state register rather than lagging it.
      cs_n_d = !(state_d inside {ST_ADDR_SETUP, ST_ADDR_STROBE, ST_DATA_SETUP, ST_DATA_STROBE});
      wr_n_d = !(state_d inside {ST_ADDR_STROBE, ST_DATA_STROBE});
      a0_d   = a0_q;
      d_d    = d_q;
      if (state_d == ST_ADDR_SETUP) begin
         a0_d = 1'b0;
         d_d  = addr_d;
      end else if (state_d == ST_DATA_SETUP) begin
         a0_d = 1'b1;
         d_d  = data_d;
      end
      ready_d = (state_d != ST_INIT) && (cnt_fifo_next < DEPTH_C);
      busy_d  = (state_d != ST_IDLE) || (cnt_fifo_next != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= LD_INIT;
         addr_q      <= '0;
         data_q      <= '0;
         cache_q     <= '0;
         cache_vld_q <= 1'b0;
         cs_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         a0_q        <= 1'b0;
         d_q         <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cache_q     <= cache_d;
         cache_vld_q <= cache_vld_d;
         cs_n_q      <= cs_n_d;
         wr_n_q      <= wr_n_d;
         a0_q        <= a0_d;
         d_q         <= d_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready  = ready_q;
   assign o_CS_n     = cs_n_q;
   assign o_WR_n     = wr_n_q;
   assign o_A0       = a0_q;
   assign o_D        = d_q;
   assign busy       = busy_q;
   assign fifo_count = cnt_fifo;

endmodule
